// File: rtl/ex_muldiv_stage.sv
// EX pipeline stage: ALU, branch target, and an iterative 32-cycle multiplier with HI/LO.
// Define EX_MULDIV_DIV_EN to add the 32-cycle restoring divider (DIV/DIVU).
module ex_muldiv_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  wb,
   input  logic [2:0]  m,
   input  logic [2:0]  ex,
   input  logic [7:0]  pc,
   input  logic [31:0] reg1,
   input  logic [31:0] reg2,
   input  logic [31:0] sign_extend,
   input  logic [5:0]  funct,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   output logic        out_valid,
   output logic [1:0]  out_wb,
   output logic [2:0]  out_m,
   output logic [31:0] out_alu_result,
   output logic [31:0] out_write_data,
   output logic [4:0]  out_write_reg,
   output logic        out_zero,
   output logic [7:0]  out_branch_target
);

`ifdef EX_MULDIV_DIV_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1} state_t;
`endif

   state_t      state_r;
   logic        ready_r;
   logic [4:0]  cnt_r;
   logic [63:0] acc_r;
   logic [31:0] opb_r;
   logic        neg_lo_r;
   logic [31:0] hi_r;
   logic [31:0] lo_r;

   logic        accept_s;
   logic        start_mul_s;
   logic        start_div_s;
   logic        signed_op_s;
   logic        slt_s;
   logic [31:0] alu_s;
   logic        a_neg_s;
   logic        b_neg_s;
   logic [31:0] a_abs_s;
   logic [31:0] b_abs_s;
   logic [32:0] mul_sum_s;
   logic [63:0] mul_next_s;
   logic [63:0] prod_s;

   assign in_ready = ready_r;
   assign accept_s = ready_r & in_valid;
   assign slt_s    = $signed(reg1) < $signed(reg2);

   // ALU result and multi-cycle operation decode
   always_comb begin
      alu_s       = 32'd0;
      start_mul_s = 1'b0;
      start_div_s = 1'b0;
      signed_op_s = 1'b0;
      case (ex[1:0])
         2'b00: alu_s = reg1 + sign_extend;
         2'b01: alu_s = reg1 - reg2;
         2'b10: begin
            case (funct)
               6'h20, 6'h21: alu_s = reg1 + reg2;
               6'h22, 6'h23: alu_s = reg1 - reg2;
               6'h24:        alu_s = reg1 & reg2;
               6'h25:        alu_s = reg1 | reg2;
               6'h2A:        alu_s = {31'd0, slt_s};
               6'h10:        alu_s = hi_r;
               6'h12:        alu_s = lo_r;
               6'h18: begin
                  start_mul_s = 1'b1;
                  signed_op_s = 1'b1;
               end
               6'h19:        start_mul_s = 1'b1;
`ifdef EX_MULDIV_DIV_EN
               6'h1A: begin
                  start_div_s = 1'b1;
                  signed_op_s = 1'b1;
               end
               6'h1B:        start_div_s = 1'b1;
`endif
               default:      alu_s = 32'd0;
            endcase
         end
         2'b11: alu_s = reg1 & sign_extend;
         default: alu_s = 32'd0;
      endcase
   end

   // Signed operations run on magnitudes; signs are reapplied on completion
   assign a_neg_s = signed_op_s & reg1[31];
   assign b_neg_s = signed_op_s & reg2[31];
   assign a_abs_s = a_neg_s ? (32'd0 - reg1) : reg1;
   assign b_abs_s = b_neg_s ? (32'd0 - reg2) : reg2;

   // acc holds {partial product, remaining multiplier bits}; one add-shift per cycle
   assign mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opb_r} : 33'd0);
   assign mul_next_s = {mul_sum_s, acc_r[31:1]};
   assign prod_s     = neg_lo_r ? (64'd0 - mul_next_s) : mul_next_s;

`ifdef EX_MULDIV_DIV_EN
   logic        neg_hi_r;
   logic [32:0] div_diff_s;
   logic [63:0] div_next_s;
   logic [31:0] quot_s;
   logic [31:0] rem_s;

   // acc holds {remainder, dividend shifting out / quotient shifting in}
   assign div_diff_s = acc_r[63:31] - {1'b0, opb_r};
   assign div_next_s = div_diff_s[32] ? {acc_r[62:0], 1'b0}
                                      : {div_diff_s[31:0], acc_r[30:0], 1'b1};
   assign quot_s     = neg_lo_r ? (32'd0 - div_next_s[31:0])  : div_next_s[31:0];
   assign rem_s      = neg_hi_r ? (32'd0 - div_next_s[63:32]) : div_next_s[63:32];
`endif

   // Control FSM, HI/LO and EX/MEM output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r           <= ST_IDLE;
         ready_r           <= 1'b1;
         cnt_r             <= 5'd0;
         acc_r             <= 64'd0;
         opb_r             <= 32'd0;
         neg_lo_r          <= 1'b0;
         hi_r              <= 32'd0;
         lo_r              <= 32'd0;
`ifdef EX_MULDIV_DIV_EN
         neg_hi_r          <= 1'b0;
`endif
         out_valid         <= 1'b0;
         out_wb            <= 2'd0;
         out_m             <= 3'd0;
         out_alu_result    <= 32'd0;
         out_write_data    <= 32'd0;
         out_write_reg     <= 5'd0;
         out_zero          <= 1'b0;
         out_branch_target <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s && start_mul_s) begin
                  state_r  <= ST_MUL;
                  ready_r  <= 1'b0;
                  cnt_r    <= 5'd0;
                  acc_r    <= {32'd0, a_abs_s};
                  opb_r    <= b_abs_s;
                  neg_lo_r <= a_neg_s ^ b_neg_s;
`ifdef EX_MULDIV_DIV_EN
               end else if (accept_s && start_div_s) begin
                  state_r  <= ST_DIV;
                  ready_r  <= 1'b0;
                  cnt_r    <= 5'd0;
                  acc_r    <= {32'd0, a_abs_s};
                  opb_r    <= b_abs_s;
                  // divide-by-zero keeps the all-ones quotient unsigned
                  neg_lo_r <= (a_neg_s ^ b_neg_s) & (reg2 != 32'd0);
                  neg_hi_r <= a_neg_s;
`endif
               end else begin
                  state_r  <= ST_IDLE;
                  ready_r  <= 1'b1;
               end
            end
            ST_MUL: begin
               cnt_r <= cnt_r + 5'd1;
               acc_r <= mul_next_s;
               if (cnt_r == 5'd31) begin
                  state_r    <= ST_IDLE;
                  ready_r    <= 1'b1;
                  hi_r       <= prod_s[63:32];
                  lo_r       <= prod_s[31:0];
               end else begin
                  state_r    <= ST_MUL;
               end
            end
`ifdef EX_MULDIV_DIV_EN
            ST_DIV: begin
               cnt_r <= cnt_r + 5'd1;
               acc_r <= div_next_s;
               if (cnt_r == 5'd31) begin
                  state_r    <= ST_IDLE;
                  ready_r    <= 1'b1;
                  hi_r       <= rem_s;
                  lo_r       <= quot_s;
               end else begin
                  state_r    <= ST_DIV;
               end
            end
`endif
            default: begin
               state_r <= ST_IDLE;
               ready_r <= 1'b1;
            end
         endcase

         if (accept_s) begin
            out_valid         <= 1'b1;
            // a multi-cycle start is forwarded as a bubble with no side effects
            if (start_mul_s || start_div_s) begin
               out_wb <= 2'd0;
               out_m  <= 3'd0;
            end else begin
               out_wb <= wb;
               out_m  <= m;
            end
            out_alu_result    <= alu_s;
            out_write_data    <= reg2;
            out_write_reg     <= ex[2] ? rd : rt;
            out_zero          <= (alu_s == 32'd0);
            out_branch_target <= pc + {sign_extend[5:0], 2'b00};
         end else begin
            out_valid <= 1'b0;
            out_wb    <= 2'd0;
            out_m     <= 3'd0;
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Directed self-checking bench for ex_muldiv_stage (ALU, branch, MULT/MULTU, reset abort, optional DIV).
module tb_ex_muldiv_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  wb;
   logic [2:0]  m;
   logic [2:0]  ex;
   logic [7:0]  pc;
   logic [31:0] reg1;
   logic [31:0] reg2;
   logic [31:0] sign_extend;
   logic [5:0]  funct;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic        out_valid;
   logic [1:0]  out_wb;
   logic [2:0]  out_m;
   logic [31:0] out_alu_result;
   logic [31:0] out_write_data;
   logic [4:0]  out_write_reg;
   logic        out_zero;
   logic [7:0]  out_branch_target;

   int checks   = 0;
   int failures = 0;
   int lows;

   ex_muldiv_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .wb(wb), .m(m), .ex(ex), .pc(pc), .reg1(reg1), .reg2(reg2),
      .sign_extend(sign_extend), .funct(funct), .rt(rt), .rd(rd),
      .out_valid(out_valid), .out_wb(out_wb), .out_m(out_m),
      .out_alu_result(out_alu_result), .out_write_data(out_write_data),
      .out_write_reg(out_write_reg), .out_zero(out_zero),
      .out_branch_target(out_branch_target)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] e, input logic [5:0] f,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] se, input logic [7:0] p);
      in_valid    = v;
      ex          = e;
      funct       = f;
      reg1        = r1;
      reg2        = r2;
      sign_extend = se;
      pc          = p;
   endtask

   // Counts sampled cycles with in_ready low, bounded at 40
   task automatic wait_ready(output int n);
      n = 0;
      while (in_ready !== 1'b1 && n < 40) begin
         n++;
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      wb = 2'b11; m = 3'b101; rt = 5'd3; rd = 5'd7;
      drive(1'b0, 3'b000, 6'h00, 32'd0, 32'd0, 32'd0, 8'd0);
      #12;
      chk("rst_ready", in_ready, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_alu", out_alu_result, 0);
      chk("rst_bt", out_branch_target, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // signed slt, reg_dst=1
      drive(1'b1, 3'b110, 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'h0000_002A, 8'h10);
      tick();
      chk("slt_alu", out_alu_result, 32'd1);
      chk("slt_zero", out_zero, 0);
      chk("slt_valid", out_valid, 1);
      chk("slt_wb", out_wb, 2'b11);
      chk("slt_m", out_m, 3'b101);
      chk("slt_wreg", out_write_reg, 5'd7);
      chk("slt_wdata", out_write_data, 32'd1);
      chk("slt_bt", out_branch_target, 8'hB8);

      drive(1'b1, 3'b110, 6'h20, 32'h7FFF_FFFF, 32'd1, 32'd0, 8'd0);
      tick();
      chk("add_wrap", out_alu_result, 32'h8000_0000);
      drive(1'b1, 3'b110, 6'h23, 32'd5, 32'd5, 32'd0, 8'd0);
      tick();
      chk("subu_alu", out_alu_result, 32'd0);
      chk("subu_zero", out_zero, 1);
      drive(1'b1, 3'b110, 6'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 8'd0);
      tick();
      chk("and_alu", out_alu_result, 32'h00F0_00F0);
      drive(1'b1, 3'b110, 6'h25, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 8'd0);
      tick();
      chk("or_alu", out_alu_result, 32'hFFF0_FFF0);
      drive(1'b1, 3'b000, 6'h00, 32'd100, 32'd0, 32'hFFFF_FFFC, 8'd0);
      tick();
      chk("addi_alu", out_alu_result, 32'd96);
      chk("addi_wreg", out_write_reg, 5'd3);
      drive(1'b1, 3'b011, 6'h00, 32'hFFFF_0000, 32'd0, 32'h1234_FFFF, 8'd0);
      tick();
      chk("andi_alu", out_alu_result, 32'h1234_0000);

      // idle slot: bubble, data held
      drive(1'b0, 3'b110, 6'h20, 32'd1, 32'd1, 32'd0, 8'd0);
      tick();
      chk("idle_valid", out_valid, 0);
      chk("idle_wb", out_wb, 0);
      chk("idle_m", out_m, 0);
      chk("idle_hold", out_alu_result, 32'h1234_0000);
      chk("idle_ready", in_ready, 1);

      drive(1'b1, 3'b110, 6'h3F, 32'd9, 32'd9, 32'd0, 8'd0);
      tick();
      chk("unl_alu", out_alu_result, 32'd0);
      chk("unl_wb", out_wb, 2'b11);

      drive(1'b1, 3'b001, 6'h00, 32'd5, 32'd5, 32'd2, 8'hFC);
      tick();
      chk("br_target", out_branch_target, 8'h04);
      chk("br_zero", out_zero, 1);

      // MULT -2 * 3
      drive(1'b1, 3'b110, 6'h18, 32'hFFFF_FFFE, 32'd3, 32'd0, 8'd0);
      tick();
      chk("mult_valid", out_valid, 1);
      chk("mult_wb", out_wb, 0);
      chk("mult_m", out_m, 0);
      chk("mult_ready", in_ready, 0);
      drive(1'b1, 3'b110, 6'h10, 32'd0, 32'd0, 32'd0, 8'd0);
      tick();
      chk("mult_stall_valid", out_valid, 0);
      wait_ready(lows);
      chk("mult_stall_len", lows, 31);
      tick();
      chk("mfhi_mult", out_alu_result, 32'hFFFF_FFFF);
      drive(1'b1, 3'b110, 6'h12, 32'd0, 32'd0, 32'd0, 8'd0);
      tick();
      chk("mflo_mult", out_alu_result, 32'hFFFF_FFFA);

      // MULTU all-ones squared
      drive(1'b1, 3'b110, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 8'd0);
      tick();
      chk("multu_wb", out_wb, 0);
      chk("multu_valid", out_valid, 1);
      drive(1'b1, 3'b110, 6'h10, 32'd0, 32'd0, 32'd0, 8'd0);
      wait_ready(lows);
      chk("multu_stall_len", lows, 32);
      tick();
      chk("mfhi_multu", out_alu_result, 32'hFFFF_FFFE);
      drive(1'b1, 3'b110, 6'h12, 32'd0, 32'd0, 32'd0, 8'd0);
      tick();
      chk("mflo_multu", out_alu_result, 32'd1);

`ifdef EX_MULDIV_DIV_EN
      drive(1'b1, 3'b110, 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'd0, 8'd0);
      tick();
      chk("div_wb", out_wb, 0);
      drive(1'b1, 3'b110, 6'h12, 32'd0, 32'd0, 32'd0, 8'd0);
      wait_ready(lows);
      chk("div_stall_len", lows, 32);
      tick();
      chk("div_lo", out_alu_result, 32'hFFFF_FFFD);
      drive(1'b1, 3'b110, 6'h10, 32'd0, 32'd0, 32'd0, 8'd0);
      tick();
      chk("div_hi", out_alu_result, 32'hFFFF_FFFF);
      drive(1'b1, 3'b110, 6'h1B, 32'd9, 32'd0, 32'd0, 8'd0);
      tick();
      drive(1'b1, 3'b110, 6'h12, 32'd0, 32'd0, 32'd0, 8'd0);
      wait_ready(lows);
      chk("divz_stall_len", lows, 32);
      tick();
      chk("divz_lo", out_alu_result, 32'hFFFF_FFFF);
      drive(1'b1, 3'b110, 6'h10, 32'd0, 32'd0, 32'd0, 8'd0);
      tick();
      chk("divz_hi", out_alu_result, 32'd9);
`else
      drive(1'b1, 3'b110, 6'h1A, 32'd9, 32'd0, 32'd0, 8'd0);
      tick();
      chk("nodiv_alu", out_alu_result, 32'd0);
      chk("nodiv_wb", out_wb, 2'b11);
      chk("nodiv_ready", in_ready, 1);
      drive(1'b1, 3'b110, 6'h12, 32'd0, 32'd0, 32'd0, 8'd0);
      tick();
      chk("nodiv_lo", out_alu_result, 32'd1);
      drive(1'b1, 3'b110, 6'h10, 32'd0, 32'd0, 32'd0, 8'd0);
      tick();
      chk("nodiv_hi", out_alu_result, 32'hFFFF_FFFE);
`endif

      // reset in the middle of a multiply
      drive(1'b1, 3'b110, 6'h18, 32'd3, 32'd5, 32'd0, 8'h40);
      tick();
      drive(1'b0, 3'b110, 6'h12, 32'd0, 32'd0, 32'd0, 8'd0);
      for (int i = 0; i < 10; i++) tick();
      chk("abort_pre_ready", in_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ready", in_ready, 1);
      chk("abort_valid", out_valid, 0);
      chk("abort_wdata", out_write_data, 0);
      chk("abort_bt", out_branch_target, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 3'b110, 6'h12, 32'd0, 32'd0, 32'd0, 8'd0);
      tick();
      chk("abort_mflo_valid", out_valid, 1);
      chk("abort_mflo", out_alu_result, 32'd0);
      drive(1'b1, 3'b110, 6'h10, 32'd0, 32'd0, 32'd0, 8'd0);
      tick();
      chk("abort_mfhi", out_alu_result, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
